// File: rtl/spi_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkt_pkg
// Summary  : Packet layout, FSM state encoding and byte/word extraction
//            helpers shared by the SPI packet reader.
// Revision : 1.0
// ============================================================================
package spi_pkt_pkg;

   localparam int         PKT_BYTES   = 16;
   localparam int         PKT_BITS    = PKT_BYTES * 8;
   localparam logic [7:0] HEADER_BYTE = 8'hAA;

   // Byte offsets within the packet, byte 0 is the first byte on the wire
   localparam logic [3:0] OFF_HDR    = 4'd0;
   localparam logic [3:0] OFF_QUAT_W = 4'd1;
   localparam logic [3:0] OFF_QUAT_X = 4'd3;
   localparam logic [3:0] OFF_QUAT_Y = 4'd5;
   localparam logic [3:0] OFF_QUAT_Z = 4'd7;
   localparam logic [3:0] OFF_GYRO_X = 4'd9;
   localparam logic [3:0] OFF_GYRO_Y = 4'd11;
   localparam logic [3:0] OFF_GYRO_Z = 4'd13;
   localparam logic [3:0] OFF_FLAGS  = 4'd15;

   localparam logic [2:0] FLAG_QUAT_BIT = 3'd0;
   localparam logic [2:0] FLAG_GYRO_BIT = 3'd1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      CHECK = 3'd4,
      GAP   = 3'd5
   } state_e;

   typedef struct packed {
      logic signed [15:0] quat_w;
      logic signed [15:0] quat_x;
      logic signed [15:0] quat_y;
      logic signed [15:0] quat_z;
      logic signed [15:0] gyro_x;
      logic signed [15:0] gyro_y;
      logic signed [15:0] gyro_z;
      logic               quat_valid;
      logic               gyro_valid;
   } fields_t;

   // Byte 0 lands in the top byte of the shift register after 128 shifts
   function automatic logic [7:0] pkt_byte(input logic [PKT_BITS-1:0] pkt,
                                           input logic [3:0]          off);
      logic [6:0] lsb;
      lsb = 7'(PKT_BITS - 8) - {off, 3'b000};
      return pkt[lsb +: 8];
   endfunction

   function automatic logic [15:0] pkt_word(input logic [PKT_BITS-1:0] pkt,
                                            input logic [3:0]          off);
      logic [6:0] lsb;
      lsb = 7'(PKT_BITS - 16) - {off, 3'b000};
      return pkt[lsb +: 16];
   endfunction

   function automatic logic pkt_bit(input logic [PKT_BITS-1:0] pkt,
                                    input logic [3:0]          off,
                                    input logic [2:0]          idx);
      logic [6:0] pos;
      pos = 7'(PKT_BITS - 8) - {off, 3'b000} + {4'b0000, idx};
      return pkt[pos];
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sck_gen
// Summary  : Mode-0 SCK generator; toggles every CLK_DIV clocks while enabled
//            and flags the clock edge on which SCK rises or falls.
// Revision : 1.0
// ============================================================================
module spi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sck,
   output logic rise_stb,
   output logic fall_stb
);
   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sck_q, sck_d;
   logic             half_done;

   assign half_done = enable && (cnt_q == CNT_W'(CLK_DIV - 1));

   // Disabled means counter parked at zero and SCK low, ready for a fresh phase
   always_comb begin
      cnt_d = '0;
      sck_d = 1'b0;
      if (enable) begin
         cnt_d = half_done ? '0 : cnt_q + CNT_W'(1);
         sck_d = half_done ? ~sck_q : sck_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   assign sck      = sck_q;
   assign rise_stb = half_done && !sck_q;
   assign fall_stb = half_done &&  sck_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_pkt_rx
// Summary  : SPI Mode-0 master that reads one 16-byte sensor packet, checks
//            the header byte and unpacks quaternion / gyro fields.
// Revision : 1.0
// ============================================================================
module spi_master_pkt_rx
   import spi_pkt_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               cs_n,
   output logic               sck,
   output logic               mosi,
   input  logic               miso,
   output logic               pkt_valid,
   output logic               hdr_err,
   output logic signed [15:0] quat_w,
   output logic signed [15:0] quat_x,
   output logic signed [15:0] quat_y,
   output logic signed [15:0] quat_z,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               quat_valid,
   output logic               gyro_valid
);
   localparam int WAIT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   state_e              state_q, state_d;
   logic                cs_n_q, cs_n_d;
   logic [PKT_BITS-1:0] shift_q, shift_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [3:0]          byte_cnt_q, byte_cnt_d;
   logic                last_q, last_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                pkt_valid_q, pkt_valid_d;
   logic                hdr_err_q, hdr_err_d;
   fields_t             fields_q, fields_d;

   logic sck_en, rise_stb, fall_stb;
   logic at_last_bit, div_done, gap_done;

   // After the final falling edge the generator is parked so SCK stays low
   assign sck_en      = (state_q == SETUP) || ((state_q == XFER) && !last_q);
   assign at_last_bit = (byte_cnt_q == 4'(PKT_BYTES - 1)) && (bit_cnt_q == 3'd7);
   assign div_done    = (wait_q == WAIT_W'(CLK_DIV - 1));
   assign gap_done    = (wait_q == WAIT_W'(GAP_CYC - 1));

   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk      (clk),
      .reset    (reset),
      .enable   (sck_en),
      .sck      (sck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cs_n_q      <= 1'b1;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         last_q      <= 1'b0;
         wait_q      <= '0;
         pkt_valid_q <= 1'b0;
         hdr_err_q   <= 1'b0;
         fields_q    <= '0;
      end else begin
         state_q     <= state_d;
         cs_n_q      <= cs_n_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         last_q      <= last_d;
         wait_q      <= wait_d;
         pkt_valid_q <= pkt_valid_d;
         hdr_err_q   <= hdr_err_d;
         fields_q    <= fields_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)                state_d = SETUP;
         SETUP:   if (rise_stb)             state_d = XFER;
         XFER:    if (last_q && div_done)   state_d = HOLD;
         HOLD:    if (div_done)             state_d = CHECK;
         CHECK:                             state_d = GAP;
         GAP:     if (gap_done)             state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   always_comb begin
      cs_n_d      = cs_n_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      last_d      = last_q;
      wait_d      = '0;
      pkt_valid_d = 1'b0;
      hdr_err_d   = 1'b0;
      fields_d    = fields_q;

      if ((state_q == IDLE) && (state_d == SETUP)) begin
         cs_n_d     = 1'b0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         last_d     = 1'b0;
      end

      if (rise_stb)
         shift_d = {shift_q[PKT_BITS-2:0], miso};

      // Position advances on the falling edge and freezes on the very last bit
      if (fall_stb) begin
         if (at_last_bit)
            last_d = 1'b1;
         else
            {byte_cnt_d, bit_cnt_d} = {byte_cnt_q, bit_cnt_q} + 7'd1;
      end

      if ((state_d == state_q) &&
          ((state_q == HOLD) || (state_q == GAP) || ((state_q == XFER) && last_q)))
         wait_d = wait_q + WAIT_W'(1);

      if ((state_q == HOLD) && (state_d == CHECK))
         cs_n_d = 1'b1;

      if (state_q == CHECK) begin
         if (pkt_byte(shift_q, OFF_HDR) == HEADER_BYTE) begin
            pkt_valid_d         = 1'b1;
            fields_d.quat_w     = pkt_word(shift_q, OFF_QUAT_W);
            fields_d.quat_x     = pkt_word(shift_q, OFF_QUAT_X);
            fields_d.quat_y     = pkt_word(shift_q, OFF_QUAT_Y);
            fields_d.quat_z     = pkt_word(shift_q, OFF_QUAT_Z);
            fields_d.gyro_x     = pkt_word(shift_q, OFF_GYRO_X);
            fields_d.gyro_y     = pkt_word(shift_q, OFF_GYRO_Y);
            fields_d.gyro_z     = pkt_word(shift_q, OFF_GYRO_Z);
            fields_d.quat_valid = pkt_bit(shift_q, OFF_FLAGS, FLAG_QUAT_BIT);
            fields_d.gyro_valid = pkt_bit(shift_q, OFF_FLAGS, FLAG_GYRO_BIT);
         end else begin
            hdr_err_d = 1'b1;
         end
      end
   end

   assign busy       = (state_q != IDLE);
   assign cs_n       = cs_n_q;
   assign mosi       = 1'b0;
   assign pkt_valid  = pkt_valid_q;
   assign hdr_err    = hdr_err_q;
   assign quat_w     = fields_q.quat_w;
   assign quat_x     = fields_q.quat_x;
   assign quat_y     = fields_q.quat_y;
   assign quat_z     = fields_q.quat_z;
   assign gyro_x     = fields_q.gyro_x;
   assign gyro_y     = fields_q.gyro_y;
   assign gyro_z     = fields_q.gyro_z;
   assign quat_valid = fields_q.quat_valid;
   assign gyro_valid = fields_q.gyro_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_pkt_rx
// Summary  : Directed bench for spi_master_pkt_rx with a behavioural Mode-0
//            slave; instance A runs CLK_DIV=4, instance B runs CLK_DIV=2.
// Revision : 1.0
// ============================================================================
module tb_spi_master_pkt_rx;
   localparam int GAP_CYC = 8;
   localparam int BOUND   = 3000;

   localparam logic [127:0] PKT1 = 128'hAA400000_10FFF000_010005FF_FB800003;
   localparam logic [127:0] PKT3 = 128'hAA123456_789ABCDE_F0012345_6789ABFE;
   localparam logic [113:0] EXP1 = {16'h4000, 16'h0010, 16'hFFF0, 16'h0001,
                                    16'h0005, 16'hFFFB, 16'h8000, 1'b1, 1'b1};
   localparam logic [113:0] EXP3 = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                    16'h0123, 16'h4567, 16'h89AB, 1'b0, 1'b1};

   logic clk = 1'b0;
   logic reset;

   logic start_a, miso_a, busy_a, cs_n_a, sck_a, mosi_a, pv_a, he_a, qv_a, gv_a;
   logic signed [15:0] qw_a, qx_a, qy_a, qz_a, gx_a, gy_a, gz_a;
   logic start_b, miso_b, busy_b, cs_n_b, sck_b, mosi_b, pv_b, he_b, qv_b, gv_b;
   logic signed [15:0] qw_b, qx_b, qy_b, qz_b, gx_b, gy_b, gz_b;

   logic [113:0] fields_a;
   logic [127:0] tx_a = '0, tx_b = '0;
   logic [7:0]   idx_a = '0, idx_b = '0;
   logic         sck_pa = 1'b0, sck_pb = 1'b0, cs_pa = 1'b1;
   int rises_a = 0, rises_b = 0, pv_cnt_a = 0, he_cnt_a = 0, both_cnt = 0;
   int hi_run = 0, last_gap = 0, cs_fall_a = 0;
   int n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   spi_master_pkt_rx #(.CLK_DIV(4), .GAP_CYC(GAP_CYC)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .cs_n(cs_n_a),
      .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .pkt_valid(pv_a), .hdr_err(he_a),
      .quat_w(qw_a), .quat_x(qx_a), .quat_y(qy_a), .quat_z(qz_a),
      .gyro_x(gx_a), .gyro_y(gy_a), .gyro_z(gz_a),
      .quat_valid(qv_a), .gyro_valid(gv_a)
   );

   spi_master_pkt_rx #(.CLK_DIV(2), .GAP_CYC(GAP_CYC)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .cs_n(cs_n_b),
      .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .pkt_valid(pv_b), .hdr_err(he_b),
      .quat_w(qw_b), .quat_x(qx_b), .quat_y(qy_b), .quat_z(qz_b),
      .gyro_x(gx_b), .gyro_y(gy_b), .gyro_z(gz_b),
      .quat_valid(qv_b), .gyro_valid(gv_b)
   );

   assign fields_a = {qw_a, qx_a, qy_a, qz_a, gx_a, gy_a, gz_a, qv_a, gv_a};

   // Slave model: presents the next MSB-first bit after every SCK falling edge
   assign miso_a = idx_a[7] ? 1'b0 : tx_a[7'd127 - idx_a[6:0]];
   assign miso_b = idx_b[7] ? 1'b0 : tx_b[7'd127 - idx_b[6:0]];

   always @(posedge clk) begin
      if (cs_n_a)                 idx_a <= 8'd0;
      else if (sck_pa && !sck_a)  idx_a <= idx_a + 8'd1;
      if (cs_n_b)                 idx_b <= 8'd0;
      else if (sck_pb && !sck_b)  idx_b <= idx_b + 8'd1;
      if (!sck_pa && sck_a) rises_a <= rises_a + 1;
      if (!sck_pb && sck_b) rises_b <= rises_b + 1;
      if (pv_a) pv_cnt_a <= pv_cnt_a + 1;
      if (he_a) he_cnt_a <= he_cnt_a + 1;
      if ((pv_a && he_a) || (pv_b && he_b)) both_cnt <= both_cnt + 1;
      if (cs_n_a) begin
         hi_run <= hi_run + 1;
      end else begin
         if (cs_pa) begin
            last_gap  <= hi_run;
            cs_fall_a <= cs_fall_a + 1;
         end
         hi_run <= 0;
      end
      sck_pa <= sck_a;
      sck_pb <= sck_b;
      cs_pa  <= cs_n_a;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle_a(input string tag);
      int n = 0;
      while (busy_a && n < BOUND) begin tick(); n++; end
      chk(tag, busy_a, 1'b0);
   endtask

   // Launch one packet on instance A; lat = cycles from accept edge to first pulse
   task automatic run_a(input logic [127:0] data, input string tag, output int lat);
      tx_a    = data;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk({tag, "_accept"}, {busy_a, cs_n_a, mosi_a}, 3'b100);
      lat = 0;
      while (!pv_a && !he_a && lat < BOUND) begin tick(); lat++; end
   endtask

   initial begin
      int lat, r0, p0, h0, f0, n;
      logic [31:0] rnd0, rnd1, rnd2, rnd3;

      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) tick();
      chk("reset_ctrl", {cs_n_a, sck_a, mosi_a, busy_a, pv_a, he_a}, 6'b100000);
      chk("reset_fields", fields_a, 114'd0);

      // Start presented in the very first cycle after reset release
      reset = 1'b0;
      r0 = rises_a;
      run_a(PKT1, "pkt1", lat);
      chk("pkt1_lat", lat, 1033);
      chk("pkt1_pulse", {pv_a, he_a}, 2'b10);
      chk("pkt1_fields", fields_a, EXP1);
      tick();
      chk("pkt1_pulse_width", {pv_a, he_a}, 2'b00);
      wait_idle_a("pkt1_idle");
      chk("pkt1_rises", rises_a - r0, 128);

      rnd0 = $urandom; rnd1 = $urandom; rnd2 = $urandom; rnd3 = $urandom;
      run_a({8'h55, rnd0, rnd1, rnd2, rnd3[23:0]}, "bad_hdr", lat);
      chk("bad_hdr_lat", lat, 1033);
      chk("bad_hdr_pulse", {pv_a, he_a}, 2'b01);
      tick();
      chk("bad_hdr_fields_held", fields_a, EXP1);
      wait_idle_a("bad_hdr_idle");

      // start held high: exactly two back-to-back reads, then release
      p0 = pv_cnt_a; f0 = cs_fall_a; r0 = rises_a;
      tx_a    = PKT3;
      start_a = 1'b1;
      n = 0;
      while ((pv_cnt_a - p0) < 2 && n < 3 * BOUND) begin tick(); n++; end
      start_a = 1'b0;
      wait_idle_a("held_idle");
      chk("held_pkts", pv_cnt_a - p0, 2);
      chk("held_cs_falls", cs_fall_a - f0, 2);
      chk("held_rises", rises_a - r0, 256);
      chk("held_gap_ge_min", last_gap >= GAP_CYC, 1'b1);
      chk("flags_fe_fields", fields_a, EXP3);

      // Abort after byte 7 has been clocked in
      tx_a    = PKT3;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (idx_a < 8'd64 && n < BOUND) begin tick(); n++; end
      chk("abort_reached_byte8", idx_a >= 8'd64, 1'b1);
      p0 = pv_cnt_a; h0 = he_cnt_a;
      reset = 1'b1;
      tick();
      chk("abort_ctrl", {cs_n_a, sck_a, busy_a, pv_a, he_a}, 5'b10000);
      chk("abort_fields", fields_a, 114'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("abort_no_pulse", {pv_cnt_a - p0, he_cnt_a - h0}, 64'd0);

      run_a(PKT1, "post_abort", lat);
      chk("post_abort_lat", lat, 1033);
      chk("post_abort_pulse", {pv_a, he_a}, 2'b10);
      chk("post_abort_fields", fields_a, EXP1);
      wait_idle_a("post_abort_idle");

      // CLK_DIV=2 instance
      tx_b    = PKT3;
      r0      = rises_b;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      lat = 0;
      while (!pv_b && !he_b && lat < BOUND) begin tick(); lat++; end
      chk("div2_lat", lat, 517);
      chk("div2_pulse", {pv_b, he_b}, 2'b10);
      chk("div2_fields", {qw_b, gz_b, qv_b, gv_b}, {16'h1234, 16'h89AB, 1'b0, 1'b1});
      n = 0;
      while (busy_b && n < BOUND) begin tick(); n++; end
      chk("div2_idle", busy_b, 1'b0);
      chk("div2_rises", rises_b - r0, 128);

      chk("never_both_pulses", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, expected finish before 2 ms");
      $fatal(1);
   end

endmodule
`default_nettype wire
